// File: rtl/decode_execute_reg_pkg.sv
// Shared definitions for the Decode->Execute pipeline register: widths, NZCV bit map,
// condition codes and the packed control bundle carried across the D/E boundary.
package decode_execute_reg_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 4;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   typedef enum logic [3:0] {
      COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
      COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
      COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
      COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE
   } condCode_e;

   typedef struct packed {
      logic n;
      logic z;
      logic c;
      logic v;
   } nzcv_t;

   typedef struct packed {
      logic       valid;
      logic       pcSrc;
      logic       regWrite;
      logic       memtoReg;
      logic       memWrite;
      logic       branch;
      logic       aluSrc;
      logic [1:0] aluControl;
      logic [1:0] flagWrite;
      logic [3:0] cond;
   } ctrlBundle_t;

endpackage

// File: rtl/decode_execute_reg_pipe_field_reg.sv
// Generic pipeline field register: async active-low reset, synchronous clear (bubble)
// that takes priority over the enable (hold when low).
module pipe_field_reg #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   input  logic         clr,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   // Clear beats hold so a flush still lands while the stage is stalled.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q <= {W{1'b0}};
      end else if (clr) begin
         q <= {W{1'b0}};
      end else if (en) begin
         q <= d;
      end else begin
         q <= q;
      end
   end

endmodule

// File: rtl/decode_execute_reg.sv
// Decode->Execute pipeline register with hazard stall/flush, plus the architectural
// NZCV flag register reloaded from the Execute-stage condition logic.
module decode_execute_reg
   import decode_execute_reg_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              StallE,
   input  logic              FlushE,
   input  logic              PCSrcD,
   input  logic              RegWriteD,
   input  logic              MemtoRegD,
   input  logic              MemWriteD,
   input  logic              BranchD,
   input  logic              ALUSrcD,
   input  logic [1:0]        ALUControlD,
   input  logic [1:0]        FlagWriteD,
   input  logic [3:0]        CondD,
   input  logic [DATA_W-1:0] RD1D,
   input  logic [DATA_W-1:0] RD2D,
   input  logic [DATA_W-1:0] ExtImmD,
   input  logic [ADDR_W-1:0] RA1D,
   input  logic [ADDR_W-1:0] RA2D,
   input  logic [ADDR_W-1:0] WA3D,
   input  logic [3:0]        FlagsNextE,
   output logic              ValidE,
   output logic              PCSrcE,
   output logic              RegWriteE,
   output logic              MemtoRegE,
   output logic              MemWriteE,
   output logic              BranchE,
   output logic              ALUSrcE,
   output logic [1:0]        ALUControlE,
   output logic [1:0]        FlagWriteE,
   output logic [3:0]        CondE,
   output logic [DATA_W-1:0] RD1E,
   output logic [DATA_W-1:0] RD2E,
   output logic [DATA_W-1:0] ExtImmE,
   output logic [ADDR_W-1:0] RA1E,
   output logic [ADDR_W-1:0] RA2E,
   output logic [ADDR_W-1:0] WA3E,
   output logic [3:0]        FlagsE
);

   localparam int CTRL_W = $bits(ctrlBundle_t);
   localparam int DP_W   = 3 * DATA_W;
   localparam int AD_W   = 3 * ADDR_W;

   ctrlBundle_t       ctrlD;
   ctrlBundle_t       ctrlE;
   logic [DP_W-1:0]   dataD;
   logic [DP_W-1:0]   dataE;
   logic [AD_W-1:0]   addrD;
   logic [AD_W-1:0]   addrE;
   nzcv_t             flagsQ;
   logic              loadEn;

   assign loadEn = ~StallE;

   // Valid rides in the control group so a flush clears it with the write-enables.
   assign ctrlD = {1'b1, PCSrcD, RegWriteD, MemtoRegD, MemWriteD, BranchD, ALUSrcD,
                   ALUControlD, FlagWriteD, CondD};
   assign dataD = {RD1D, RD2D, ExtImmD};
   assign addrD = {RA1D, RA2D, WA3D};

   pipe_field_reg #(.W(CTRL_W)) uCtrlReg (
      .clk(clk), .reset(reset), .en(loadEn), .clr(FlushE), .d(ctrlD), .q(ctrlE)
   );

   pipe_field_reg #(.W(DP_W)) uDataReg (
      .clk(clk), .reset(reset), .en(loadEn), .clr(FlushE), .d(dataD), .q(dataE)
   );

   pipe_field_reg #(.W(AD_W)) uAddrReg (
      .clk(clk), .reset(reset), .en(loadEn), .clr(FlushE), .d(addrD), .q(addrE)
   );

   // Flags retire with the instruction leaving E, so a flush of its successor must not block them.
   pipe_field_reg #(.W(4)) uFlagReg (
      .clk(clk), .reset(reset), .en(loadEn), .clr(1'b0), .d(FlagsNextE), .q(flagsQ)
   );

   assign ValidE      = ctrlE.valid;
   assign PCSrcE      = ctrlE.pcSrc;
   assign RegWriteE   = ctrlE.regWrite;
   assign MemtoRegE   = ctrlE.memtoReg;
   assign MemWriteE   = ctrlE.memWrite;
   assign BranchE     = ctrlE.branch;
   assign ALUSrcE     = ctrlE.aluSrc;
   assign ALUControlE = ctrlE.aluControl;
   assign FlagWriteE  = ctrlE.flagWrite;
   assign CondE       = ctrlE.cond;

   assign {RD1E, RD2E, ExtImmE} = dataE;
   assign {RA1E, RA2E, WA3E}    = addrE;

   assign FlagsE[FLAG_N] = flagsQ.n;
   assign FlagsE[FLAG_Z] = flagsQ.z;
   assign FlagsE[FLAG_C] = flagsQ.c;
   assign FlagsE[FLAG_V] = flagsQ.v;

endmodule

// File: tb/tb_decode_execute_reg.sv
// Scoreboard bench for decode_execute_reg: directed vectors push hand-written expected
// E-stage contents; a monitor pops and compares one entry after each clock edge.
module tb_decode_execute_reg;

   typedef struct packed {
      logic        pcSrc;
      logic        regWrite;
      logic        memtoReg;
      logic        memWrite;
      logic        branch;
      logic        aluSrc;
      logic [1:0]  aluControl;
      logic [1:0]  flagWrite;
      logic [3:0]  cond;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [31:0] extImm;
      logic [3:0]  ra1;
      logic [3:0]  ra2;
      logic [3:0]  wa3;
   } dVec_t;

   typedef struct packed {
      logic       valid;
      dVec_t      f;
      logic [3:0] flags;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        StallE = 1'b0;
   logic        FlushE = 1'b0;
   dVec_t       dIn = '0;
   logic [3:0]  FlagsNextE = 4'b0000;

   logic        ValidE, PCSrcE, RegWriteE, MemtoRegE, MemWriteE, BranchE, ALUSrcE;
   logic [1:0]  ALUControlE, FlagWriteE;
   logic [3:0]  CondE, RA1E, RA2E, WA3E, FlagsE;
   logic [31:0] RD1E, RD2E, ExtImmE;

   dVec_t       actF;
   exp_t        expQ[$];
   int          nCompared = 0;
   int          nMismatched = 0;

   dVec_t instA, instB, instC, instCmp, instBeq, instX;
   dVec_t zeroF;

   always #5 clk = ~clk;

   decode_execute_reg dut (
      .clk(clk), .reset(reset), .StallE(StallE), .FlushE(FlushE),
      .PCSrcD(dIn.pcSrc), .RegWriteD(dIn.regWrite), .MemtoRegD(dIn.memtoReg),
      .MemWriteD(dIn.memWrite), .BranchD(dIn.branch), .ALUSrcD(dIn.aluSrc),
      .ALUControlD(dIn.aluControl), .FlagWriteD(dIn.flagWrite), .CondD(dIn.cond),
      .RD1D(dIn.rd1), .RD2D(dIn.rd2), .ExtImmD(dIn.extImm),
      .RA1D(dIn.ra1), .RA2D(dIn.ra2), .WA3D(dIn.wa3), .FlagsNextE(FlagsNextE),
      .ValidE(ValidE), .PCSrcE(PCSrcE), .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE),
      .MemWriteE(MemWriteE), .BranchE(BranchE), .ALUSrcE(ALUSrcE),
      .ALUControlE(ALUControlE), .FlagWriteE(FlagWriteE), .CondE(CondE),
      .RD1E(RD1E), .RD2E(RD2E), .ExtImmE(ExtImmE),
      .RA1E(RA1E), .RA2E(RA2E), .WA3E(WA3E), .FlagsE(FlagsE)
   );

   assign actF = {PCSrcE, RegWriteE, MemtoRegE, MemWriteE, BranchE, ALUSrcE,
                  ALUControlE, FlagWriteE, CondE, RD1E, RD2E, ExtImmE, RA1E, RA2E, WA3E};

   task automatic checkPipe(input string name, input logic expValid, input dVec_t expF);
      nCompared++;
      if ({ValidE, actF} !== {expValid, expF}) begin
         nMismatched++;
         $display("FAIL %s pipe: got %h want %h", name, {ValidE, actF}, {expValid, expF});
      end
   endtask

   task automatic checkFlags(input string name, input logic [3:0] expFlags);
      nCompared++;
      if (FlagsE !== expFlags) begin
         nMismatched++;
         $display("FAIL %s flags: got %b want %b", name, FlagsE, expFlags);
      end
   endtask

   // Monitor: one expected entry per clock edge that the stimulus scheduled.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (expQ.size() != 0) begin
            e = expQ.pop_front();
            checkPipe("edge", e.valid, e.f);
            checkFlags("edge", e.flags);
         end
      end
   end

   task automatic step(input logic st, input logic fl, input dVec_t d, input logic [3:0] fn,
                       input logic expValid, input dVec_t expF, input logic [3:0] expFlags);
      exp_t e;
      @(negedge clk);
      StallE = st;
      FlushE = fl;
      dIn = d;
      FlagsNextE = fn;
      e.valid = expValid;
      e.f = expF;
      e.flags = expFlags;
      expQ.push_back(e);
   endtask

   initial begin
      zeroF = '0;

      instA = '0;
      instA.regWrite = 1'b1;   instA.aluSrc = 1'b1;     instA.aluControl = 2'b01;
      instA.cond = 4'hE;       instA.rd1 = 32'h1234_5678; instA.rd2 = 32'h0000_00FF;
      instA.extImm = 32'h0000_0010; instA.ra1 = 4'd1; instA.ra2 = 4'd2; instA.wa3 = 4'd5;

      instB = '1;

      instC = '0;
      instC.pcSrc = 1'b1;      instC.memWrite = 1'b1;   instC.branch = 1'b1;
      instC.flagWrite = 2'b11; instC.rd1 = 32'hDEAD_BEEF; instC.extImm = 32'hCAFE_0001;
      instC.wa3 = 4'd9;

      instCmp = '0;
      instCmp.aluControl = 2'b01; instCmp.flagWrite = 2'b11; instCmp.cond = 4'hE;
      instCmp.rd1 = 32'h0000_0007; instCmp.extImm = 32'h0000_0007; instCmp.ra1 = 4'd3;
      instCmp.aluSrc = 1'b1;

      instBeq = '0;
      instBeq.pcSrc = 1'b1;    instBeq.branch = 1'b1;   instBeq.cond = 4'h0;
      instBeq.extImm = 32'h0000_0040; instBeq.aluSrc = 1'b1;

      instX = '0;
      instX.regWrite = 1'b1;   instX.cond = 4'h1;       instX.rd1 = 32'hA5A5_A5A5;
      instX.rd2 = 32'h5A5A_5A5A; instX.wa3 = 4'd12;

      // Reset asserted mid-cycle with live D inputs.
      dIn = instA;
      FlagsNextE = 4'b1111;
      #1 reset = 1'b0;
      #1;
      checkPipe("reset_initial", 1'b0, zeroF);
      checkFlags("reset_initial", 4'b0000);
      @(negedge clk);
      reset = 1'b1;

      step(1'b0, 1'b0, instA,   4'b0000, 1'b1, instA,   4'b0000); // pass-through
      step(1'b1, 1'b0, instB,   4'b1010, 1'b1, instA,   4'b0000); // stall 1
      step(1'b1, 1'b0, instB,   4'b1010, 1'b1, instA,   4'b0000); // stall 2
      step(1'b0, 1'b0, instB,   4'b0011, 1'b1, instB,   4'b0011); // B after release, all-ones
      step(1'b0, 1'b1, instC,   4'b0100, 1'b0, zeroF,   4'b0100); // flush, flags still load
      step(1'b0, 1'b0, instA,   4'b0000, 1'b1, instA,   4'b0000);
      step(1'b0, 1'b0, instCmp, 4'b0000, 1'b1, instCmp, 4'b0000); // CMP enters E
      step(1'b0, 1'b0, instBeq, 4'b0100, 1'b1, instBeq, 4'b0100); // CMP flags retire
      step(1'b1, 1'b0, instX,   4'b1010, 1'b1, instBeq, 4'b0100); // BEQ stalled
      step(1'b0, 1'b0, instA,   4'b0100, 1'b1, instA,   4'b0100);
      step(1'b1, 1'b1, instB,   4'b1111, 1'b0, zeroF,   4'b0100); // flush+stall: bubble, flags hold
      step(1'b0, 1'b0, instB,   4'b1001, 1'b1, instB,   4'b1001);

      // Asynchronous reset in the middle of a cycle with a full E stage.
      @(negedge clk);
      StallE = 1'b0;
      FlushE = 1'b0;
      #2 reset = 1'b0;
      #1;
      checkPipe("reset_midrun", 1'b0, zeroF);
      checkFlags("reset_midrun", 4'b0000);
      #1 reset = 1'b1;

      step(1'b0, 1'b0, instA,   4'b0110, 1'b1, instA,   4'b0110); // first edge after reset

      repeat (3) @(posedge clk);
      #2;
      nCompared++;
      if (expQ.size() != 0) begin
         nMismatched++;
         $display("FAIL scoreboard_drain: got %0d pending want 0", expQ.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
